mem_request_unit: RTL and testbench

- Sequences the memory requests for each instruction between the control unit and the datapath/cache interface.
- Issues the instruction fetch and, for memory instructions, one data read or write, then generates the PC advance enable.
- Parametrised successor of the single-cycle request glue:
  - configurable address/data width;
  - registered data request;
  - explicit halt state;
  - retired-instruction counter;
  - optional request timeout.

---
 rtl/mem_request_unit.sv | 143 ++++++++++++++
 tb/tb_mem_request_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - per-instruction fetch/data request sequencer with PC advance and retire count
// Optional request timeout enabled by defining REQ_TIMEOUT_EN.
module mem_request_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              ctr_dREN,
  input  logic              ctr_dWEN,
  input  logic              halt,
  input  logic [ADDR_W-1:0] daddr_in,
  input  logic [DATA_W-1:0] dstore_in,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              pc_en,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output logic              req_err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              req_err_q, req_err_d;
  logic              pc_en_c;

`ifdef REQ_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    retired_d = retired_q;
    req_err_d = req_err_q;
    pc_en_c   = 1'b0;
`ifdef REQ_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (halt) begin
            state_d = HALTED;
          end else if (ctr_dREN || ctr_dWEN) begin
            // a store wins over a load when both are flagged
            addr_d  = daddr_in;
            store_d = dstore_in;
            ren_d   = ctr_dREN & ~ctr_dWEN;
            wen_d   = ctr_dWEN;
            state_d = DATA;
`ifdef REQ_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            pc_en_c   = 1'b1;
            retired_d = retired_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en_c   = 1'b1;
          retired_d = retired_q + 1'b1;
          state_d   = FETCH;
`ifdef REQ_TIMEOUT_EN
        end else if (tcnt_q == TCNT_LAST) begin
          req_err_d = 1'b1;
          state_d   = HALTED;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FETCH;
      addr_q    <= '0;
      store_q   <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      retired_q <= '0;
      req_err_q <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      retired_q <= retired_d;
      req_err_q <= req_err_d;
`ifdef REQ_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign imemREN   = (state_q == FETCH);
  assign dmemREN   = (state_q == DATA) && ren_q;
  assign dmemWEN   = (state_q == DATA) && wen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign pc_en     = pc_en_c;
  assign halted    = (state_q == HALTED);
  assign retired   = retired_q;
`ifdef REQ_TIMEOUT_EN
  assign req_err   = req_err_q;
`else
  assign req_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - directed self-checking bench for mem_request_unit
module tb_mem_request_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int TMO    = 8;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ihit, dhit, ctr_dREN, ctr_dWEN, halt;
  logic [ADDR_W-1:0] daddr_in;
  logic [DATA_W-1:0] dstore_in;
  logic              imemREN, dmemREN, dmemWEN, pc_en, halted, req_err;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic [CNT_W-1:0]  retired;

  int errors = 0;
  int checks = 0;

  mem_request_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ctr_dREN(ctr_dREN), .ctr_dWEN(ctr_dWEN), .halt(halt),
    .daddr_in(daddr_in), .dstore_in(dstore_in),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .pc_en(pc_en),
    .halted(halted), .retired(retired), .req_err(req_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_load(input logic [ADDR_W-1:0] a);
    tick();
    ihit = 1'b1; ctr_dREN = 1'b1; daddr_in = a;
    @(negedge CLK);
    check("ld_issue_pc_en", pc_en, 1'b0);
    tick();
    ihit = 1'b0; ctr_dREN = 1'b0; daddr_in = 32'h55;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; ihit = 0; dhit = 0; ctr_dREN = 0; ctr_dWEN = 0; halt = 0;
    daddr_in = '0; dstore_in = '0;
    @(negedge CLK);
    check("rst_imemREN", imemREN, 1'b1);
    check("rst_dmemREN", dmemREN, 1'b0);
    check("rst_dmemWEN", dmemWEN, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired, 0);
    check("rst_req_err", req_err, 1'b0);
    check("rst_dmemaddr", dmemaddr, 0);

    // three non-memory instructions
    tick(); nRST = 1'b1; ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("alu_pc_en", pc_en, 1'b1);
      check("alu_dmemREN", dmemREN, 1'b0);
      tick();
    end
    ihit = 1'b0;
    @(negedge CLK);
    check("alu_retired", retired, 3);
    check("idle_pc_en", pc_en, 1'b0);

    // load at 0x100, dhit on the 4th data cycle, ihit ignored meanwhile
    issue_load(32'h100);
    @(negedge CLK);
    check("ld_imemREN", imemREN, 1'b0);
    check("ld_dmemREN", dmemREN, 1'b1);
    check("ld_dmemWEN", dmemWEN, 1'b0);
    check("ld_dmemaddr", dmemaddr, 32'h100);
    for (int i = 0; i < 2; i++) begin
      tick(); ihit = 1'b1;
      @(negedge CLK);
      check("ld_wait_pc_en", pc_en, 1'b0);
      check("ld_wait_addr", dmemaddr, 32'h100);
    end
    tick(); ihit = 1'b0; dhit = 1'b1;
    @(negedge CLK);
    check("ld_dhit_pc_en", pc_en, 1'b1);
    tick(); dhit = 1'b0;
    @(negedge CLK);
    check("ld_done_pc_en", pc_en, 1'b0);
    check("ld_done_imemREN", imemREN, 1'b1);
    check("ld_done_retired", retired, 4);
    check("ld_hold_addr", dmemaddr, 32'h100);

    // both read and write flagged: write wins
    tick(); ihit = 1'b1; ctr_dREN = 1'b1; ctr_dWEN = 1'b1;
    daddr_in = 32'h200; dstore_in = 32'hDEADBEEF;
    @(negedge CLK);
    check("st_issue_pc_en", pc_en, 1'b0);
    tick(); ihit = 1'b0; ctr_dREN = 1'b0; ctr_dWEN = 1'b0; dstore_in = '0; dhit = 1'b1;
    @(negedge CLK);
    check("st_dmemWEN", dmemWEN, 1'b1);
    check("st_dmemREN", dmemREN, 1'b0);
    check("st_dmemstore", dmemstore, 32'hDEADBEEF);
    check("st_dmemaddr", dmemaddr, 32'h200);
    check("st_pc_en", pc_en, 1'b1);
    tick(); dhit = 1'b0;
    @(negedge CLK);
    check("st_retired", retired, 5);
    check("st_imemREN", imemREN, 1'b1);

`ifdef REQ_TIMEOUT_EN
    issue_load(32'h300);
    for (int i = 0; i < TMO; i++) begin
      @(negedge CLK);
      check("tmo_wait_pc_en", pc_en, 1'b0);
      tick();
    end
    @(negedge CLK);
    check("tmo_req_err", req_err, 1'b1);
    check("tmo_halted", halted, 1'b1);
    check("tmo_retired", retired, 5);
    check("tmo_dmemREN", dmemREN, 1'b0);
    tick(); nRST = 1'b0;
    @(negedge CLK);
    check("tmo_rst_req_err", req_err, 1'b0);
    tick(); nRST = 1'b1;
    issue_load(32'h304);
    for (int i = 0; i < TMO - 1; i++) begin
      @(negedge CLK);
      check("tmo2_wait_pc_en", pc_en, 1'b0);
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    check("tmo2_edge_pc_en", pc_en, 1'b1);
    tick(); dhit = 1'b0;
    @(negedge CLK);
    check("tmo2_req_err", req_err, 1'b0);
    check("tmo2_halted", halted, 1'b0);
    check("tmo2_retired", retired, 1);
`else
    issue_load(32'h300);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("notmo_wait_pc_en", pc_en, 1'b0);
      tick();
    end
    @(negedge CLK);
    check("notmo_req_err", req_err, 1'b0);
    check("notmo_halted", halted, 1'b0);
    check("notmo_dmemREN", dmemREN, 1'b1);
    tick(); dhit = 1'b1;
    @(negedge CLK);
    check("notmo_pc_en", pc_en, 1'b1);
    tick(); dhit = 1'b0;
    @(negedge CLK);
    check("notmo_retired", retired, 6);
`endif

    // halt takes priority over a store; only reset leaves HALTED
    tick(); ihit = 1'b1; halt = 1'b1; ctr_dWEN = 1'b1;
    @(negedge CLK);
    check("halt_issue_pc_en", pc_en, 1'b0);
    tick(); halt = 1'b0; ctr_dWEN = 1'b0;
    @(negedge CLK);
    check("halt_halted", halted, 1'b1);
    check("halt_dmemWEN", dmemWEN, 1'b0);
    check("halt_imemREN", imemREN, 1'b0);
    check("halt_pc_en", pc_en, 1'b0);
    tick();
    @(negedge CLK);
    check("halt_stay_pc_en", pc_en, 1'b0);
    check("halt_stay", halted, 1'b1);
    tick(); ihit = 1'b0; nRST = 1'b0;
    @(negedge CLK);
    check("halt_rst_halted", halted, 1'b0);
    check("halt_rst_imemREN", imemREN, 1'b1);
    tick(); nRST = 1'b1;

    // reset asserted mid-request with dhit present drops it
    issue_load(32'h400);
    dhit = 1'b1;
    #1;
    check("mid_pre_dmemREN", dmemREN, 1'b1);
    #1; nRST = 1'b0;
    #1;
    check("mid_rst_dmemREN", dmemREN, 1'b0);
    check("mid_rst_imemREN", imemREN, 1'b1);
    check("mid_rst_pc_en", pc_en, 1'b0);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_addr", dmemaddr, 0);
    dhit = 1'b0;
    tick(); nRST = 1'b1;

    // 17 retirements on a 4-bit counter wrap to 1; dhit in FETCH is ignored
    ihit = 1'b1; dhit = 1'b1;
    repeat (17) @(posedge CLK);
    #1; ihit = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    check("wrap_retired", retired, 1);
    check("wrap_imemREN", imemREN, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
